// File: rtl/branch_update_queue_if.sv
// Branch update queue bundle: resolved-instruction input,
// predictor update output, redirect strobe and occupancy.
interface branch_update_queue_if #(
   parameter int GHR_WIDTH = 10,
   parameter int DEPTH     = 4
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic                 flush;
   logic                 res_valid;
   logic                 res_ready;
   logic                 res_is_branch;
   logic                 res_is_jump;
   logic                 res_actual_taken;
   logic [GHR_WIDTH-1:0] res_pht_index;
   logic [31:0]          res_pc;
   logic [31:0]          res_pred_next;
   logic [31:0]          res_actual_target;

   logic                 is_branch_out;
   logic                 is_jump_out;
   logic                 is_taken_out;
   logic                 is_miss_out;
   logic [GHR_WIDTH-1:0] last_pht_index_out;
   logic [31:0]          inst_pc_out;
   logic [31:0]          target_out;
   logic                 redirect_valid;
   logic [31:0]          redirect_pc;
   logic [CW-1:0]        count;

   modport master (
      output flush, res_valid, res_is_branch, res_is_jump,
      output res_actual_taken, res_pht_index, res_pc,
      output res_pred_next, res_actual_target,
      input  res_ready, is_branch_out, is_jump_out,
      input  is_taken_out, is_miss_out, last_pht_index_out,
      input  inst_pc_out, target_out, redirect_valid,
      input  redirect_pc, count
   );

   modport slave (
      input  flush, res_valid, res_is_branch, res_is_jump,
      input  res_actual_taken, res_pht_index, res_pc,
      input  res_pred_next, res_actual_target,
      output res_ready, is_branch_out, is_jump_out,
      output is_taken_out, is_miss_out, last_pht_index_out,
      output inst_pc_out, target_out, redirect_valid,
      output redirect_pc, count
   );
endinterface

// File: rtl/branch_update_queue.sv
// Resolves branches, queues them for predictor update and
// raises a one-cycle redirect on mispredict.
module branch_update_queue #(
   parameter int GHR_WIDTH = 10,
   parameter int DEPTH     = 4
) (
   input logic               clk,
   input logic               rst,
   branch_update_queue_if.slave bq
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH) + 1;

   typedef struct packed {
      logic                 br;
      logic                 jp;
      logic                 tk;
      logic                 miss;
      logic [GHR_WIDTH-1:0] pht;
      logic [31:0]          pc;
      logic [31:0]          tgt;
   } ent_t;

   ent_t          mem_q [DEPTH];
   logic [AW-1:0] head_q, head_d;
   logic [AW-1:0] tail_q, tail_d;
   logic [CW-1:0] count_q, count_d;
   ent_t          upd_q, upd_d;
   logic          rv_q, rv_d;
   logic [31:0]   rpc_q, rpc_d;

   logic          taken, miss, accept, push, pop;
   logic [31:0]   act_next;
   ent_t          in_e;

   assign taken = bq.res_is_jump |
                  (bq.res_is_branch & bq.res_actual_taken);
   assign act_next = taken ? bq.res_actual_target
                           : bq.res_pc + 32'd8;
   assign miss = (act_next != bq.res_pred_next);

   assign bq.res_ready = (count_q != CW'(DEPTH));
   assign accept = bq.res_valid & bq.res_ready & ~bq.flush;
   assign push = accept & (bq.res_is_branch | bq.res_is_jump);
   assign pop = (count_q != '0) & ~bq.flush;

   assign in_e = '{br:   bq.res_is_branch,
                   jp:   bq.res_is_jump,
                   tk:   taken,
                   miss: miss,
                   pht:  bq.res_pht_index,
                   pc:   bq.res_pc,
                   tgt:  bq.res_actual_target};

   // Next-state: flush clears queue and outputs, keeps redirect_pc.
   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      upd_d   = '0;
      rv_d    = 1'b0;
      rpc_d   = rpc_q;
      if (bq.flush) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         if (push) tail_d = tail_q + AW'(1);
         if (pop) begin
            head_d = head_q + AW'(1);
            upd_d  = mem_q[head_q];
         end
         count_d = count_q + CW'(push) - CW'(pop);
         if (accept && miss) begin
            rv_d  = 1'b1;
            rpc_d = act_next;
         end
      end
   end

   // Control state and registered outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         upd_q   <= '0;
         rv_q    <= 1'b0;
         rpc_q   <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         upd_q   <= upd_d;
         rv_q    <= rv_d;
         rpc_q   <= rpc_d;
      end
   end

   // Entry storage; contents are only meaningful below count.
   always_ff @(posedge clk) begin
      if (push) mem_q[tail_q] <= in_e;
   end

   assign bq.is_branch_out      = upd_q.br;
   assign bq.is_jump_out        = upd_q.jp;
   assign bq.is_taken_out       = upd_q.tk;
   assign bq.is_miss_out        = upd_q.miss;
   assign bq.last_pht_index_out = upd_q.pht;
   assign bq.inst_pc_out        = upd_q.pc;
   assign bq.target_out         = upd_q.tgt;
   assign bq.redirect_valid     = rv_q;
   assign bq.redirect_pc        = rpc_q;
   assign bq.count              = count_q;
endmodule

// File: tb/tb_branch_update_queue.sv
// Scoreboard bench for branch_update_queue: queue-based
// reference model plus decoupled output monitor.
module tb_branch_update_queue;
   localparam int GW = 10;
   localparam int D  = 4;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   branch_update_queue_if #(.GHR_WIDTH(GW), .DEPTH(D)) bq ();
   branch_update_queue #(.GHR_WIDTH(GW), .DEPTH(D)) dut (
      .clk(clk),
      .rst(rst),
      .bq (bq)
   );

   typedef struct packed {
      logic          br;
      logic          jp;
      logic          tk;
      logic          miss;
      logic [GW-1:0] pht;
      logic [31:0]   pc;
      logic [31:0]   tgt;
   } upd_t;

   upd_t        mq[$];
   upd_t        eu[$];
   logic [31:0] er[$];
   logic [31:0] last_rpc = '0;

   int pass_n = 0;
   int tot_n  = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      tot_n++;
      if (act === exp) pass_n++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   task automatic fail(input string nm);
      tot_n++;
      $display("FAIL %s", nm);
   endtask

   // Reference model: behaviour of one clock edge.
   bit          m_acc;
   upd_t        m_e;
   logic [31:0] m_nx;
   always @(posedge clk) begin
      if (rst) begin
         m_acc = bq.res_valid && !bq.flush && (mq.size() < D);
         if (bq.flush) begin
            mq.delete();
         end else begin
            if (mq.size() > 0) eu.push_back(mq.pop_front());
            if (m_acc) begin
               m_e.br  = bq.res_is_branch;
               m_e.jp  = bq.res_is_jump;
               m_e.tk  = bq.res_is_jump ||
                         (bq.res_is_branch && bq.res_actual_taken);
               m_nx    = m_e.tk ? bq.res_actual_target
                                : bq.res_pc + 32'd8;
               m_e.miss = (m_nx != bq.res_pred_next);
               m_e.pht = bq.res_pht_index;
               m_e.pc  = bq.res_pc;
               m_e.tgt = bq.res_actual_target;
               if (m_e.miss) begin
                  er.push_back(m_nx);
                  last_rpc = m_nx;
               end
               if (m_e.br || m_e.jp) mq.push_back(m_e);
            end
         end
      end
   end

   always @(negedge rst) begin
      mq.delete();
      eu.delete();
      er.delete();
      last_rpc = '0;
   end

   // Monitor: compare DUT outputs against expectations.
   upd_t w_e;
   always @(negedge clk) begin
      if (rst) begin
         chk("count", 32'(bq.count), mq.size());
         chk("res_ready", 32'(bq.res_ready), 32'(mq.size() < D));
         if (bq.is_branch_out || bq.is_jump_out) begin
            if (eu.size() == 0) begin
               fail("upd_unexpected");
            end else begin
               w_e = eu.pop_front();
               chk("upd_br", 32'(bq.is_branch_out), 32'(w_e.br));
               chk("upd_jp", 32'(bq.is_jump_out), 32'(w_e.jp));
               chk("upd_tk", 32'(bq.is_taken_out), 32'(w_e.tk));
               chk("upd_miss", 32'(bq.is_miss_out), 32'(w_e.miss));
               chk("upd_pht", 32'(bq.last_pht_index_out),
                   32'(w_e.pht));
               chk("upd_pc", bq.inst_pc_out, w_e.pc);
               chk("upd_tgt", bq.target_out, w_e.tgt);
            end
         end else begin
            chk("upd_missing", eu.size(), 0);
            chk("idle_flags",
                32'({bq.is_taken_out, bq.is_miss_out}), 0);
            chk("idle_pht", 32'(bq.last_pht_index_out), 0);
            chk("idle_pc", bq.inst_pc_out, 0);
            chk("idle_tgt", bq.target_out, 0);
         end
         if (bq.redirect_valid) begin
            if (er.size() == 0) fail("redirect_unexpected");
            else chk("redirect_pc", bq.redirect_pc, er.pop_front());
         end else begin
            chk("redirect_missing", er.size(), 0);
         end
         chk("redirect_hold", bq.redirect_pc, last_rpc);
      end
   end

   task automatic send(input bit br, input bit jp, input bit tk,
                       input logic [GW-1:0] pht,
                       input logic [31:0] pc,
                       input logic [31:0] pred,
                       input logic [31:0] tgt,
                       input bit rf);
      bit ok;
      int n;
      n = 0;
      bq.res_is_branch     = br;
      bq.res_is_jump       = jp;
      bq.res_actual_taken  = tk;
      bq.res_pht_index     = pht;
      bq.res_pc            = pc;
      bq.res_pred_next     = pred;
      bq.res_actual_target = tgt;
      bq.res_valid         = 1'b1;
      do begin
         bq.flush = rf && ($urandom_range(0, 9) == 0);
         ok = bq.res_ready && !bq.flush;
         @(negedge clk);
         n++;
      end while (!ok && n < 100);
      if (!ok) fail("send_timeout");
      bq.res_valid = 1'b0;
      bq.flush     = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic chk_zero(input string nm);
      chk({nm, "_count"}, 32'(bq.count), 0);
      chk({nm, "_upd"}, 32'({bq.is_branch_out, bq.is_jump_out,
                             bq.is_taken_out, bq.is_miss_out}), 0);
      chk({nm, "_pht"}, 32'(bq.last_pht_index_out), 0);
      chk({nm, "_pc"}, bq.inst_pc_out, 0);
      chk({nm, "_tgt"}, bq.target_out, 0);
      chk({nm, "_rv"}, 32'(bq.redirect_valid), 0);
      chk({nm, "_rpc"}, bq.redirect_pc, 0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int r;
      logic [31:0] pc, tgt, pred;
      bq.flush = 0;
      bq.res_valid = 0;
      bq.res_is_branch = 0;
      bq.res_is_jump = 0;
      bq.res_actual_taken = 0;
      bq.res_pht_index = '0;
      bq.res_pc = '0;
      bq.res_pred_next = '0;
      bq.res_actual_target = '0;
      #1;
      chk_zero("reset");
      @(negedge clk);
      rst = 1'b1;
      idle(2);

      send(1, 0, 1, 10'h3, 32'hbfc00010, 32'hbfc00018,
           32'hbfc00124, 0);
      chk("t1_rv", 32'(bq.redirect_valid), 1);
      chk("t1_rpc", bq.redirect_pc, 32'hbfc00124);
      @(negedge clk);
      chk("t1_upd_pc", bq.inst_pc_out, 32'hbfc00010);
      idle(2);

      send(1, 0, 0, 10'h5, 32'hbfc00020, 32'hbfc00028,
           32'hbfc00300, 0);
      idle(3);

      for (int i = 0; i < D + 2; i++)
         send(1, 0, i[0], GW'(i), 32'h100 + 32'(i) * 32'h10,
              32'h108 + 32'(i) * 32'h10, 32'h800, 0);
      idle(4);

      send(0, 1, 0, 10'h7, 32'h300, 32'h400, 32'h400, 0);
      send(0, 0, 0, 10'h0, 32'h500, 32'h600, 32'h0, 0);
      idle(3);

      for (int i = 0; i < 3; i++)
         send(1, 0, 1, GW'(i), 32'h700 + 32'(i) * 32'h10,
              32'h0, 32'h900, 0);
      bq.res_is_branch = 1;
      bq.res_actual_taken = 1;
      bq.res_pc = 32'ha00;
      bq.res_pred_next = 32'ha08;
      bq.res_actual_target = 32'hb00;
      bq.res_valid = 1;
      bq.flush = 1;
      @(negedge clk);
      bq.res_valid = 0;
      bq.flush = 0;
      chk("t5_rv", 32'(bq.redirect_valid), 0);
      idle(3);

      send(1, 0, 1, 10'h9, 32'hc00, 32'hc08, 32'hd00, 0);
      #2 rst = 1'b0;
      #1 chk_zero("async_rst");
      idle(2);
      rst = 1'b1;
      idle(1);
      send(1, 0, 0, 10'h2a, 32'he00, 32'he08, 32'hf00, 0);
      @(negedge clk);
      chk("t6_upd_br", 32'(bq.is_branch_out), 1);
      idle(2);

      for (int i = 0; i < 300; i++) begin
         r   = $urandom_range(0, 3);
         pc  = $urandom & 32'hffff_fffc;
         tgt = $urandom & 32'hffff_fffc;
         case ($urandom_range(0, 2))
            0: pred = pc + 32'd8;
            1: pred = tgt;
            default: pred = $urandom;
         endcase
         if (i % 61 == 60) pc = 32'hffff_fffc;
         send(r >= 2, r == 1, $urandom_range(0, 1),
              GW'($urandom), pc, pred, tgt, 1);
         idle($urandom_range(0, 2));
      end

      idle(6);
      chk("end_upd_left", eu.size(), 0);
      chk("end_redir_left", er.size(), 0);
      $display("%0d/%0d checks passed", pass_n, tot_n);
      $finish;
   end
endmodule
